// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// instruction field positions and default reset values.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its pc+4 while
// the IF/ID register is stalled.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              clear_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic              full_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc4_o
);

  logic              full_q, full_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    // Clear (redirect flush) wins over any load or unload in the same cycle.
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// holds the IF/ID register with a one-entry skid buffer, and flushes on redirect.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [5:0]        if_id_op,
  output logic [5:0]        if_id_funct
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  // Handshake: a fetch is in flight while imem_req=1; imem_addr is held
  // stable until the cycle imem_ack=1, which completes the transfer.
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pending_q, pending_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        funct_q, funct_d;

  logic              ack_v, ifid_free, load_ifid;
  logic [ADDR_W-1:0] pc_plus4, redirect_aligned;
  logic [31:0]       src_instr;
  logic [ADDR_W-1:0] src_pc4;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc4;

  fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_rdata),
    .pc4_i    (pc_plus4),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc4_o    (skid_pc4)
  );

  always_comb begin
    ack_v            = imem_ack & req_q;
    ifid_free        = ~valid_q | ~stall;
    pc_plus4         = pc_q + PC_STEP;
    redirect_aligned = redirect_pc & ALIGN_MASK;

    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    valid_d     = valid_q & stall;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    op_d        = op_q;
    funct_d     = funct_q;
    load_ifid   = 1'b0;
    src_instr   = imem_rdata;
    src_pc4     = pc_plus4;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      case (state_q)
        S_REQ: begin
          // An unacked request must still be drained; remember where to go.
          if (req_q && !ack_v) begin
            pending_d = redirect_aligned;
            state_d   = S_DROP;
          end else begin
            pc_d    = redirect_aligned;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (ack_v) begin
            pc_d    = redirect_aligned;
            state_d = S_REQ;
          end else begin
            pending_d = redirect_aligned;
          end
        end
        default: begin
          pc_d    = redirect_aligned;
          state_d = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (ack_v) begin
            pc_d = pc_plus4;
            if (ifid_free) begin
              load_ifid = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (ifid_free) begin
            load_ifid   = 1'b1;
            src_instr   = skid_instr;
            src_pc4     = skid_pc4;
            skid_unload = 1'b1;
            state_d     = S_REQ;
          end
        end
        S_DROP: begin
          if (ack_v) begin
            pc_d    = pending_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    if (load_ifid) begin
      valid_d = 1'b1;
      instr_d = src_instr;
      pc4_d   = src_pc4;
      op_d    = src_instr[OP_HI:OP_LO];
      funct_d = src_instr[FUNCT_HI:FUNCT_LO];
    end

    req_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      pending_q <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc4_q     <= '0;
      op_q      <= '0;
      funct_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q & ALIGN_MASK;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_op    = op_q;
  assign if_id_funct = funct_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for the main stream
// plus hand-written sequences for wrap, redirect corners and mid-request reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  if_id_op;
  logic [5:0]  if_id_funct;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_op    (if_id_op),
    .if_id_funct (if_id_funct)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  localparam logic [31:0] I0 = 32'h0123_4020;
  localparam logic [31:0] I1 = 32'h8c22_0004;
  localparam logic [31:0] I2 = 32'h0043_2822;
  localparam logic [31:0] I3 = 32'h1111_0003;
  localparam logic [31:0] I4 = 32'h2408_0005;
  localparam logic [31:0] I5 = 32'h0000_000d;
  localparam logic [31:0] I6 = 32'h0c00_0010;
  localparam logic [31:0] I7 = 32'hABCD_1234;
  localparam logic [31:0] I8 = 32'h3c01_1234;
  localparam logic [31:0] I9 = 32'h0000_0008;

  vec_t vecs [19];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic stl, logic rd,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_pc4, logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.stall = stl; v.redir = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc4 = e_pc4; v.e_instr = e_instr;
    return v;
  endfunction

  // scoreboard helpers
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc4,
                           input logic [31:0] e_instr);
    logic [31:0] ei;
    ei = e_instr;
    cmp({tag, " req"},   {31'b0, imem_req},    {31'b0, e_req});
    cmp({tag, " addr"},  imem_addr,            e_addr);
    cmp({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    if (e_valid) begin
      cmp({tag, " instr"}, if_id_instr,           ei);
      cmp({tag, " pc4"},   if_id_pc4,             e_pc4);
      cmp({tag, " op"},    {26'b0, if_id_op},     {26'b0, ei[31:26]});
      cmp({tag, " funct"}, {26'b0, if_id_funct},  {26'b0, ei[5:0]});
    end
  endtask

  // driver
  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic rd, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic step(input logic ack, input logic [31:0] rdata, input logic stl,
                      input logic rd, input logic [31:0] rpc);
    drive(ack, rdata, stl, rd, rpc);
    @(negedge clk);
  endtask

  initial begin
    // Row i: outputs expected during cycle i, then inputs applied in cycle i.
    vecs[0]  = mk(0, 0,            0, 0, 0,     0, 32'h00, 0, 0,     0);
    vecs[1]  = mk(1, I0,           0, 0, 0,     1, 32'h00, 0, 0,     0);
    vecs[2]  = mk(1, I1,           0, 0, 0,     1, 32'h04, 1, 32'h04, I0);
    vecs[3]  = mk(1, I2,           0, 0, 0,     1, 32'h08, 1, 32'h08, I1);
    vecs[4]  = mk(1, I3,           1, 0, 0,     1, 32'h0C, 1, 32'h0C, I2);
    vecs[5]  = mk(1, 32'hDEADBEEF, 1, 0, 0,     0, 32'h10, 1, 32'h0C, I2);
    vecs[6]  = mk(0, 0,            1, 0, 0,     0, 32'h10, 1, 32'h0C, I2);
    vecs[7]  = mk(0, 0,            0, 0, 0,     0, 32'h10, 1, 32'h0C, I2);
    vecs[8]  = mk(0, 0,            0, 0, 0,     1, 32'h10, 1, 32'h10, I3);
    vecs[9]  = mk(0, 0,            0, 0, 0,     1, 32'h10, 0, 0,     0);
    vecs[10] = mk(0, 0,            0, 0, 0,     1, 32'h10, 0, 0,     0);
    vecs[11] = mk(1, I4,           0, 0, 0,     1, 32'h10, 0, 0,     0);
    vecs[12] = mk(0, 0,            0, 0, 0,     1, 32'h14, 1, 32'h14, I4);
    vecs[13] = mk(0, 0,            0, 1, 32'h43, 1, 32'h14, 0, 0,     0);
    vecs[14] = mk(0, 0,            0, 0, 0,     1, 32'h14, 0, 0,     0);
    vecs[15] = mk(1, I5,           0, 0, 0,     1, 32'h14, 0, 0,     0);
    vecs[16] = mk(1, I6,           0, 0, 0,     1, 32'h40, 0, 0,     0);
    vecs[17] = mk(0, 0,            0, 0, 0,     1, 32'h44, 1, 32'h44, I6);
    vecs[18] = mk(0, 0,            0, 0, 0,     1, 32'h44, 0, 0,     0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // reset state
    cmp("rst req",   {31'b0, imem_req},    32'h0);
    cmp("rst addr",  imem_addr,            32'h0);
    cmp("rst valid", {31'b0, if_id_valid}, 32'h0);
    cmp("rst instr", if_id_instr,          32'h0);
    cmp("rst pc4",   if_id_pc4,            32'h0);
    cmp("rst op",    {26'b0, if_id_op},    32'h0);
    cmp("rst funct", {26'b0, if_id_funct}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_valid, vecs[i].e_pc4, vecs[i].e_instr);
      step(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
    end

    // Redirect with same-cycle ack, unaligned target, then pc+4 wrap.
    step(1, 32'h5555_5555, 0, 1, 32'hFFFF_FFFF);
    check_out("wrap_redir", 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(1, I7, 0, 0, 0);
    check_out("wrap_fetch", 1, 32'h0000_0000, 1, 32'h0000_0000, I7);

    // Redirect while holding the skid entry: entry must be dropped.
    step(1, I8, 1, 0, 0);
    check_out("hold", 0, 32'h04, 1, 32'h0, I7);
    step(0, 0, 1, 1, 32'h100);
    check_out("hold_redir", 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_out("hold_flushed", 1, 32'h100, 0, 0, 0);

    // Two redirects while a request is outstanding: last one wins.
    step(0, 0, 0, 1, 32'h200);
    check_out("drop1", 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 1, 32'h300);
    check_out("drop2", 1, 32'h100, 0, 0, 0);
    step(1, 32'h7777_7777, 0, 0, 0);
    check_out("drop_done", 1, 32'h300, 0, 0, 0);
    step(1, I9, 0, 0, 0);
    check_out("after_drop", 1, 32'h304, 1, 32'h304, I9);

    // Reset mid-request, with an ack presented right after release.
    drive(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check_out("mid_rst", 0, 32'h0, 0, 0, 0);
    cmp("mid_rst instr", if_id_instr, 32'h0);
    drive(1, 32'hCAFE_F00D, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'hCAFE_F00D, 0, 0, 0);
    check_out("post_rst", 1, 32'h0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the PC and issues single-outstanding requests to instruction memory, which may answer with variable latency.
- Holds the IF/ID pipeline register, which presents the instruction plus split op[31:26] and funct[5:0] fields to control.
- Absorbs downstream stalls with a one-entry skid buffer and flushes on branch/jump redirect.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack
- imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0
- imem_ack  in  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1
- imem_rdata  in  32  fetched instruction
- stall  in  1  ID stage cannot consume the IF/ID register this cycle
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0)
- if_id_valid  out  1  IF/ID register holds a live instruction
- if_id_instr  out  32  fetched instruction word
- if_id_pc4  out  ADDR_W  address of the instruction + 4
- if_id_op  out  6  if_id_instr[31:26]
- if_id_funct  out  6  if_id_instr[5:0]

Behaviour:
- Reset values (async, while rst_n=0):
  - pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, state=S_REQ
  - if_id_valid=0, if_id_instr=0, if_id_pc4=0, if_id_op=0, if_id_funct=0
  - skid buffer empty
- imem_req rises in the first cycle after rst_n deasserts.
- Consume rule: the IF/ID register is consumed in any cycle with if_id_valid=1 and stall=0.
- "IF/ID free" means if_id_valid=0, or it is being consumed this cycle.
- State S_REQ (imem_req=1, imem_addr=pc):
  - ack and IF/ID free: load IF/ID with rdata and pc+4; set valid=1; pc<=pc+4; stay in S_REQ.
  - ack and IF/ID not free: write rdata and pc+4 into the skid buffer; pc<=pc+4; go to S_HOLD.
  - No ack: hold req and addr stable.
- State S_HOLD (imem_req=0):
  - Skid buffer full.
  - When IF/ID becomes free, move the skid buffer into IF/ID (valid=1), empty the skid buffer, and go to S_REQ.
- State S_DROP (imem_req=1, addr unchanged):
  - A redirect arrived while a request was outstanding.
  - Keep req and addr stable until ack, then discard rdata.
  - Then set pc<=pending_pc and go to S_REQ.
- Redirect has the highest priority, including over stall.
  - Next edge: if_id_valid<=0 and skid buffer emptied.
  - If ack arrives in the same cycle as redirect: data is discarded, pc<=redirect_pc, state S_REQ.
  - If req is outstanding with no ack: latch pending_pc<=redirect_pc and go to S_DROP.
  - If in S_HOLD: pc<=redirect_pc, state S_REQ.
  - A second redirect while in S_DROP overwrites pending_pc (last one wins).
- Timing:
  - Latency: ack in cycle N gives if_id_valid=1 at N+1.
  - Throughput: 1 instr/cycle with zero-wait memory and no stall.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W, with no flag.
- Stalled hold: while stall=1 and no redirect, all if_id_* outputs hold their values.
- Field split: if_id_op and if_id_funct are registered together with if_id_instr and are never combinationally derived from imem_rdata.
- Reset mid-request: all state clears immediately. Any in-flight ack after reset is ignored because imem_req=0.

Decomposition:
- Shared package (cpu_pkg):
  - state enum (S_REQ, S_HOLD, S_DROP)
  - OP_HI=31, OP_LO=26, FUNCT_HI=5, FUNCT_LO=0
  - NOP_INSTR=32'h0000_0000
  - default RESET_PC
- Sub-module fetch_skid: one-entry buffer holding instr and pc4, with load/unload/clear and a full flag.
- The top level holds the PC, the FSM, and the IF/ID register.

Test Plan:
- Reset release, memory always acks: imem_addr sequence 0x0,0x4,0x8. if_id_pc4 = 0x4,0x8,0xC on consecutive cycles; if_id_valid=1 from cycle 2.
- Instruction 32'h0123_4020 (add) fetched: if_id_op=6'b000000, if_id_funct=6'b100000, if_id_instr=32'h0123_4020.
- Stall=1 for 3 cycles with an ack arriving during the stall: IF/ID holds its value, the skid buffer captures the next instruction, imem_req=0 in S_HOLD. On stall release, the skid entry appears the following cycle and no instruction is lost or duplicated.
- Memory acks 3 cycles late: imem_req and imem_addr stay stable for all 3 cycles; if_id_valid=0 until the cycle after ack.
- Redirect to 0x40 while a 0x8 request awaits ack (2-cycle delay): the 0x8 data is discarded and if_id_valid=0. The next imem_addr=0x40, and the first valid if_id_pc4=0x44.
- PC=0xFFFF_FFFC fetched: if_id_pc4=0x0000_0000 and the next imem_addr=0x0. Also, redirect_pc=0x43 gives imem_addr=0x40.
